// File: rtl/esm_pkg.sv
// Shared definitions for the ESM instruction allocator: RV32 opcodes and
// the per-instruction register-usage record.
`timescale 1ns/1ps
package esm_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic use_rd;
    logic use_rs1;
    logic use_rs2;
  } reg_use_t;

  // Which architectural register fields an opcode actually reads or writes.
  function automatic reg_use_t reg_usage(input logic [6:0] opcode);
    reg_use_t u;
    u = '0;
    case (opcode)
      OP_R:                      u = '{use_rd: 1'b1, use_rs1: 1'b1, use_rs2: 1'b1};
      OP_IMM, OP_LOAD, OP_JALR:  u = '{use_rd: 1'b1, use_rs1: 1'b1, use_rs2: 1'b0};
      OP_STORE, OP_BRANCH:       u = '{use_rd: 1'b0, use_rs1: 1'b1, use_rs2: 1'b1};
      OP_LUI, OP_AUIPC, OP_JAL:  u = '{use_rd: 1'b1, use_rs1: 1'b0, use_rs2: 1'b0};
      default:                   u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/esm_reg_decode.sv
// Combinational register-field decoder: extracts rd/rs1/rs2 from an RV32
// instruction, zeroing fields the opcode does not use.
// Optional feature macro: ESM_REG_RANGE_CHECK_EN (flags fields >= regnum).
`timescale 1ns/1ps
module esm_reg_decode
  import esm_pkg::*;
#(
  parameter int regnum = 16
) (
  input  logic [24:0]                 instr,
  output logic [$clog2(regnum)-1:0]   rd,
  output logic [$clog2(regnum)-1:0]   rs1,
  output logic [$clog2(regnum)-1:0]   rs2
`ifdef ESM_REG_RANGE_CHECK_EN
  ,
  output logic                        range_err
`endif
);

  localparam int RW = $clog2(regnum);

  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  reg_use_t   use_v;

  // Raw field extraction and opcode usage lookup.
  always_comb begin
    rd_f  = instr[11:7];
    rs1_f = instr[19:15];
    rs2_f = instr[24:20];
    use_v = reg_usage(instr[6:0]);
  end

`ifdef ESM_REG_RANGE_CHECK_EN
  logic rd_oor;
  logic rs1_oor;
  logic rs2_oor;

  // Used fields naming a register beyond regnum are reported and forced to 0.
  always_comb begin
    rd_oor    = use_v.use_rd  && ({27'd0, rd_f}  >= 32'(regnum));
    rs1_oor   = use_v.use_rs1 && ({27'd0, rs1_f} >= 32'(regnum));
    rs2_oor   = use_v.use_rs2 && ({27'd0, rs2_f} >= 32'(regnum));
    range_err = rd_oor || rs1_oor || rs2_oor;
    rd  = (use_v.use_rd  && !rd_oor)  ? rd_f[RW-1:0]  : '0;
    rs1 = (use_v.use_rs1 && !rs1_oor) ? rs1_f[RW-1:0] : '0;
    rs2 = (use_v.use_rs2 && !rs2_oor) ? rs2_f[RW-1:0] : '0;
  end
`else
  // Upper field bits above RW are dropped silently in this build.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{rd_f, rs1_f, rs2_f};

  // Used fields are truncated to RW bits; unused fields read as register 0.
  always_comb begin
    rd  = use_v.use_rd  ? rd_f[RW-1:0]  : '0;
    rs1 = use_v.use_rs1 ? rs1_f[RW-1:0] : '0;
    rs2 = use_v.use_rs2 ? rs2_f[RW-1:0] : '0;
  end
`endif

endmodule

// File: rtl/esm_instr_alloc.sv
// ESM instruction allocator: accepts instructions, places each in the lowest
// free buffer slot, and strobes its decoded registers to the tracking table.
// Slots are released out of order by the issue logic.
// Optional feature macro: ESM_REG_RANGE_CHECK_EN (adds sticky reg_err output).
`timescale 1ns/1ps
module esm_instr_alloc
  import esm_pkg::*;
#(
  parameter int bs     = 32,
  parameter int regnum = 16,
  parameter int IW     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IW-1:0]               in_instr,
  output logic                        alloc_we,
  output logic [$clog2(bs)-1:0]       alloc_index,
  output logic [$clog2(regnum)-1:0]   alloc_rd,
  output logic [$clog2(regnum)-1:0]   alloc_rs1,
  output logic [$clog2(regnum)-1:0]   alloc_rs2,
  input  logic                        rel_valid,
  input  logic [$clog2(bs)-1:0]       rel_index,
  input  logic [$clog2(bs)-1:0]       rd_index,
  output logic [IW-1:0]               rd_instr,
  output logic                        rd_slot_valid,
  output logic [$clog2(bs):0]         count,
  output logic                        full,
  output logic                        empty,
  output logic                        rel_err
`ifdef ESM_REG_RANGE_CHECK_EN
  ,
  output logic                        reg_err
`endif
);

  localparam int BW = $clog2(bs);
  localparam int RW = $clog2(regnum);

  logic [bs-1:0] occ_q, occ_d;
  logic [BW:0]   count_q, count_d;
  logic          alloc_we_q, alloc_we_d;
  logic [BW-1:0] alloc_index_q, alloc_index_d;
  logic [RW-1:0] alloc_rd_q, alloc_rd_d;
  logic [RW-1:0] alloc_rs1_q, alloc_rs1_d;
  logic [RW-1:0] alloc_rs2_q, alloc_rs2_d;
  logic          rel_err_q, rel_err_d;
  logic [IW-1:0] storage_q [bs];

  logic [BW-1:0] free_idx;
  logic          accept;
  logic          rel_ok;
  logic          rel_bad;
  logic [RW-1:0] dec_rd, dec_rs1, dec_rs2;

`ifdef ESM_REG_RANGE_CHECK_EN
  logic dec_range_err;
  logic reg_err_q, reg_err_d;

  esm_reg_decode #(.regnum(regnum)) u_decode (
    .instr     (in_instr[24:0]),
    .rd        (dec_rd),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .range_err (dec_range_err)
  );
`else
  esm_reg_decode #(.regnum(regnum)) u_decode (
    .instr (in_instr[24:0]),
    .rd    (dec_rd),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2)
  );
`endif

  // Lowest-index free slot of the current (pre-release) bitmap.
  always_comb begin
    free_idx = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (!occ_q[i]) free_idx = BW'(i);
    end
  end

  // Status and handshake, all from registered state so release cannot reach in_ready.
  always_comb begin
    full          = (count_q == (BW+1)'(bs));
    empty         = (count_q == '0);
    in_ready      = !rst && !full;
    count         = count_q;
    rd_instr      = storage_q[rd_index];
    rd_slot_valid = occ_q[rd_index];
    alloc_we      = alloc_we_q;
    alloc_index   = alloc_index_q;
    alloc_rd      = alloc_rd_q;
    alloc_rs1     = alloc_rs1_q;
    alloc_rs2     = alloc_rs2_q;
    rel_err       = rel_err_q;
  end

  // Next-state: allocation sets a free bit, a valid release clears an occupied bit.
  always_comb begin
    accept  = in_valid && in_ready;
    rel_ok  = rel_valid && occ_q[rel_index];
    rel_bad = rel_valid && !occ_q[rel_index];

    occ_d = occ_q;
    if (accept) occ_d[free_idx] = 1'b1;
    if (rel_ok) occ_d[rel_index] = 1'b0;

    count_d = count_q;
    if (accept && !rel_ok) count_d = count_q + 1'b1;
    else if (!accept && rel_ok) count_d = count_q - 1'b1;

    alloc_we_d    = accept;
    alloc_index_d = accept ? free_idx : alloc_index_q;
    alloc_rd_d    = accept ? dec_rd   : alloc_rd_q;
    alloc_rs1_d   = accept ? dec_rs1  : alloc_rs1_q;
    alloc_rs2_d   = accept ? dec_rs2  : alloc_rs2_q;

    rel_err_d = rel_err_q || rel_bad;
  end

`ifdef ESM_REG_RANGE_CHECK_EN
  // Range error becomes visible together with the strobe and stays until reset.
  always_comb begin
    reg_err_d = reg_err_q || (accept && dec_range_err);
    reg_err   = reg_err_q;
  end

  // Sticky range-error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) reg_err_q <= 1'b0;
    else     reg_err_q <= reg_err_d;
  end
`endif

  // Control state registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q         <= '0;
      count_q       <= '0;
      alloc_we_q    <= 1'b0;
      alloc_index_q <= '0;
      alloc_rd_q    <= '0;
      alloc_rs1_q   <= '0;
      alloc_rs2_q   <= '0;
      rel_err_q     <= 1'b0;
    end else begin
      occ_q         <= occ_d;
      count_q       <= count_d;
      alloc_we_q    <= alloc_we_d;
      alloc_index_q <= alloc_index_d;
      alloc_rd_q    <= alloc_rd_d;
      alloc_rs1_q   <= alloc_rs1_d;
      alloc_rs2_q   <= alloc_rs2_d;
      rel_err_q     <= rel_err_d;
    end
  end

  // Instruction storage has no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (accept) storage_q[free_idx] <= in_instr;
  end

endmodule
